scr1_ialu_rvm_unit: RTL and testbench
=====================================

SCR1_IALU_RVM_UNIT -- requirements
Module: scr1_ialu_rvm_unit

Interface
REQ-001 Parameter SCR1_XLEN, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rvm_cmd_vd_i  input  1  command valid from the IALU; one-cycle request.
REQ-005 rvm_cmd_i  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rvm_op1_i  input  SCR1_XLEN  rs1 operand (multiplicand or dividend).
REQ-007 rvm_op2_i  input  SCR1_XLEN  rs2 operand (multiplier or divisor).
REQ-008 rvm_kill_i  input  1  abort the in-flight operation (pipeline flush).
REQ-009 rvm_res_o  output  SCR1_XLEN  result to the IALU main result mux.
REQ-010 rvm_res_rdy_o  output  1  result valid, one-cycle pulse; drives the IALU rvm result-ready.
REQ-011 rvm_busy_o  output  1  high while an iterative operation is in progress.

Function
REQ-012 The block SHALL implement FSM states IDLE, ITER and DONE.
REQ-013 A command SHALL be accepted on a rising edge with rvm_cmd_vd_i=1, rvm_kill_i=0 and state IDLE or DONE; operands and opcode are registered at that edge (T0).
REQ-014 rvm_cmd_vd_i SHALL be ignored in ITER; no queuing.
REQ-015 Normal path: T0 -> ITER with a 5-bit step counter = 0; one radix-2 step per edge; after the 32nd step (edge T32) -> DONE.
REQ-016 In DONE, rvm_res_rdy_o SHALL be 1 for exactly one cycle; at the next edge the FSM SHALL go to IDLE, or to ITER/DONE if a new command is accepted.
REQ-017 Multiply SHALL use shift-add over a 2*XLEN product. MUL returns the low XLEN bits. MULH treats both operands as signed. MULHSU treats op1 as signed and op2 as unsigned. MULHU treats both as unsigned. The high ops return the high XLEN bits.
REQ-018 Divide SHALL use restoring division on operand magnitudes. For DIV/REM, the quotient is negated if the operand signs differ, and the remainder takes the dividend sign. Quotient rounds toward zero.
REQ-019 Divisor = 0 fast path: at T0 -> DONE directly. DIV/DIVU return all-ones. REM/REMU return op1.
REQ-020 Signed overflow fast path (DIV/REM, op1 = 0x80000000, op2 = 0xFFFFFFFF): at T0 -> DONE. DIV returns 0x80000000; REM returns 0.
REQ-021 Fast-path latency SHALL be 1 cycle (rvm_res_rdy_o high between T0 and T1). Normal-path latency SHALL be 32 cycles (high between T32 and T33).
REQ-022 rvm_res_o SHALL be registered and updated only on entry to DONE. It holds its value until the next result.
REQ-023 rvm_busy_o SHALL equal (state == ITER).
REQ-024 rvm_kill_i=1 on an edge SHALL force IDLE and clear the counter. No rvm_res_rdy_o is issued and rvm_res_o is unchanged.
REQ-025 If rvm_kill_i and rvm_cmd_vd_i are both high on the same edge, kill wins and the command is dropped.
REQ-026 rvm_kill_i in DONE SHALL suppress the pending pulse in the following cycle only if it arrives before DONE is entered. A kill while already in DONE returns to IDLE with the pulse already issued.

Reset
REQ-027 On rst_n low, asynchronously: state = IDLE, counter = 0, rvm_res_o = 0, rvm_res_rdy_o = 0, rvm_busy_o = 0, internal operand/accumulator registers = 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation. After release, the first edge with rvm_cmd_vd_i=1 is accepted normally.

Verification
REQ-029 MUL op1=7, op2=0xFFFFFFFD -> rvm_res_o = 0xFFFFFFEB; rvm_res_rdy_o pulses 32 cycles after accept; rvm_busy_o high for 32 cycles.
REQ-030 MULHU op1 = op2 = 0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
REQ-031 DIVU 100/0 -> 0xFFFFFFFF at 1-cycle latency. REMU 100/0 -> 100. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at 1-cycle latency.
REQ-032 DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. REMU 7/2 -> 1. All at 32-cycle latency.
REQ-033 Accept DIVU, assert rvm_kill_i 10 cycles later -> no rvm_res_rdy_o, rvm_busy_o low the next cycle, rvm_res_o unchanged. A new MUL 3*4 is accepted immediately -> 12.
REQ-034 Back-to-back: a new command presented during the DONE pulse cycle is accepted. Drop rst_n mid-ITER -> all outputs 0 immediately, no pulse after release.

Source files
------------

// File: rtl/scr1_ialu_rvm_unit.sv
// RV32M multiply/divide unit for the SCR1 integer ALU.
// Multiplication uses radix-2 shift-add. Division uses restoring division.
// Both work on operand magnitudes and apply the sign correction at the end.
// A zero divisor and signed overflow complete in one cycle.
// All other operations complete after 32 iterations.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a command
//   ITER  | one radix-2 step per clock; step_cnt counts steps 0..31
//   DONE  | result registered, rvm_res_rdy_o high for this cycle only
module scr1_ialu_rvm_unit #(
    parameter int SCR1_XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rvm_cmd_vd_i,
    input  logic [2:0]           rvm_cmd_i,
    input  logic [SCR1_XLEN-1:0] rvm_op1_i,
    input  logic [SCR1_XLEN-1:0] rvm_op2_i,
    input  logic                 rvm_kill_i,
    output logic [SCR1_XLEN-1:0] rvm_res_o,
    output logic                 rvm_res_rdy_o,
    output logic                 rvm_busy_o
);

    localparam int XL = SCR1_XLEN;

    localparam logic [2:0] CMD_MUL    = 3'd0;
    localparam logic [2:0] CMD_MULH   = 3'd1;
    localparam logic [2:0] CMD_MULHSU = 3'd2;
    localparam logic [2:0] CMD_MULHU  = 3'd3;
    localparam logic [2:0] CMD_DIV    = 3'd4;
    localparam logic [2:0] CMD_DIVU   = 3'd5;
    localparam logic [2:0] CMD_REM    = 3'd6;
    localparam logic [2:0] CMD_REMU   = 3'd7;

    localparam logic [4:0]    STEP_LAST = 5'd31;
    localparam logic [XL-1:0] MIN_NEG   = {1'b1, {(XL-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      step_cnt;
    logic [2:0]      cmd_r;
    logic [XL-1:0]   opb_r;       // multiplicand or divisor magnitude
    logic [2*XL-1:0] acc_r;       // {product high, multiplier} or {remainder, quotient}
    logic            neg_res_r;   // negate the product or the quotient
    logic            neg_rem_r;   // negate the remainder

    logic            op1_sgn;
    logic            op2_sgn;
    logic [XL-1:0]   op1_mag;
    logic [XL-1:0]   op2_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_path;
    logic [XL-1:0]   fast_res;

    logic [XL:0]     mul_sum;
    logic [XL:0]     rem_sh;
    logic [XL:0]     rem_sub;
    logic            div_ge;
    logic [XL-1:0]   rem_new;
    logic [2*XL-1:0] acc_nxt;
    logic [2*XL-1:0] prod_fin;
    logic [XL-1:0]   quo_fin;
    logic [XL-1:0]   rem_fin;
    logic [XL-1:0]   fin_res;

    // Decode the incoming command: operand signs, magnitudes and the one-cycle cases.
    always_comb begin
        op1_sgn  = rvm_op1_i[XL-1] & ((rvm_cmd_i == CMD_MULH) | (rvm_cmd_i == CMD_MULHSU) |
                                      (rvm_cmd_i == CMD_DIV)  | (rvm_cmd_i == CMD_REM));
        op2_sgn  = rvm_op2_i[XL-1] & ((rvm_cmd_i == CMD_MULH) |
                                      (rvm_cmd_i == CMD_DIV)  | (rvm_cmd_i == CMD_REM));
        op1_mag  = op1_sgn ? -rvm_op1_i : rvm_op1_i;
        op2_mag  = op2_sgn ? -rvm_op2_i : rvm_op2_i;
        div_zero = rvm_cmd_i[2] & (rvm_op2_i == '0);
        div_ovf  = ((rvm_cmd_i == CMD_DIV) | (rvm_cmd_i == CMD_REM)) &
                   (rvm_op1_i == MIN_NEG) & (rvm_op2_i == '1);
        fast_path = div_zero | div_ovf;
        // cmd bit 1 separates REM/REMU from DIV/DIVU.
        // Overflow DIV returns op1 (0x80..0) and overflow REM returns zero.
        if (div_zero) begin
            fast_res = rvm_cmd_i[1] ? rvm_op1_i : '1;
        end else begin
            fast_res = rvm_cmd_i[1] ? '0 : rvm_op1_i;
        end
    end

    // One radix-2 step of the datapath, plus the sign-corrected final result.
    always_comb begin
        mul_sum = {1'b0, acc_r[2*XL-1:XL]} + (acc_r[0] ? {1'b0, opb_r} : '0);
        rem_sh  = {acc_r[2*XL-1:XL], acc_r[XL-1]};
        rem_sub = rem_sh - {1'b0, opb_r};
        div_ge  = (rem_sh >= {1'b0, opb_r});
        rem_new = div_ge ? rem_sub[XL-1:0] : rem_sh[XL-1:0];
        if (cmd_r[2]) begin
            acc_nxt = {rem_new, acc_r[XL-2:0], div_ge};
        end else begin
            acc_nxt = {mul_sum, acc_r[XL-1:1]};
        end
        prod_fin = neg_res_r ? -acc_nxt : acc_nxt;
        quo_fin  = neg_res_r ? -acc_nxt[XL-1:0] : acc_nxt[XL-1:0];
        rem_fin  = neg_rem_r ? -acc_nxt[2*XL-1:XL] : acc_nxt[2*XL-1:XL];
        case (cmd_r)
            CMD_MUL:                        fin_res = prod_fin[XL-1:0];
            CMD_MULH, CMD_MULHSU, CMD_MULHU: fin_res = prod_fin[2*XL-1:XL];
            CMD_DIV, CMD_DIVU:              fin_res = quo_fin;
            default:                        fin_res = rem_fin;
        endcase
    end

    // Control FSM with registered result, ready pulse and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            step_cnt      <= '0;
            cmd_r         <= '0;
            opb_r         <= '0;
            acc_r         <= '0;
            neg_res_r     <= 1'b0;
            neg_rem_r     <= 1'b0;
            rvm_res_o     <= '0;
            rvm_res_rdy_o <= 1'b0;
            rvm_busy_o    <= 1'b0;
        end else if (rvm_kill_i) begin
            state         <= ST_IDLE;
            step_cnt      <= '0;
            rvm_res_rdy_o <= 1'b0;
            rvm_busy_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state         <= ST_IDLE;
                    rvm_res_rdy_o <= 1'b0;
                    rvm_busy_o    <= 1'b0;
                    if (rvm_cmd_vd_i) begin
                        cmd_r     <= rvm_cmd_i;
                        neg_res_r <= op1_sgn ^ op2_sgn;
                        neg_rem_r <= op1_sgn;
                        step_cnt  <= '0;
                        if (fast_path) begin
                            state         <= ST_DONE;
                            rvm_res_o     <= fast_res;
                            rvm_res_rdy_o <= 1'b1;
                        end else begin
                            state      <= ST_ITER;
                            rvm_busy_o <= 1'b1;
                            opb_r      <= op2_mag;
                            acc_r      <= {{XL{1'b0}}, op1_mag};
                        end
                    end
                end
                ST_ITER: begin
                    acc_r <= acc_nxt;
                    if (step_cnt == STEP_LAST) begin
                        state         <= ST_DONE;
                        step_cnt      <= '0;
                        rvm_res_o     <= fin_res;
                        rvm_res_rdy_o <= 1'b1;
                        rvm_busy_o    <= 1'b0;
                    end else begin
                        step_cnt <= step_cnt + 5'd1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    step_cnt      <= '0;
                    rvm_res_rdy_o <= 1'b0;
                    rvm_busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_ialu_rvm_unit.sv
// Self-checking bench for scr1_ialu_rvm_unit.
// Results come from plain-arithmetic RV32M semantics.
// Latency comes from the divisor-zero and overflow rules.
module tb_scr1_ialu_rvm_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rvm_cmd_vd_i = 1'b0;
    logic [2:0]  rvm_cmd_i = 3'd0;
    logic [31:0] rvm_op1_i = '0;
    logic [31:0] rvm_op2_i = '0;
    logic        rvm_kill_i = 1'b0;
    logic [31:0] rvm_res_o;
    logic        rvm_res_rdy_o;
    logic        rvm_busy_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = '0;

    scr1_ialu_rvm_unit #(.SCR1_XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rvm_cmd_vd_i  (rvm_cmd_vd_i),
        .rvm_cmd_i     (rvm_cmd_i),
        .rvm_op1_i     (rvm_op1_i),
        .rvm_op2_i     (rvm_op2_i),
        .rvm_kill_i    (rvm_kill_i),
        .rvm_res_o     (rvm_res_o),
        .rvm_res_rdy_o (rvm_res_rdy_o),
        .rvm_busy_o    (rvm_busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (c)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        return (c >= 3'd4 && b == 0) ||
               ((c == 3'd4 || c == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called at a falling edge; the command is taken on the following rising edge (T0).
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        rvm_cmd_vd_i = 1'b1;
        rvm_cmd_i    = c;
        rvm_op1_i    = a;
        rvm_op2_i    = b;
        @(negedge clk);
        rvm_cmd_vd_i = 1'b0;
    endtask

    // Starts at the falling edge after T0 + start rising edges. Counts rising edges until ready.
    task automatic wait_res(input string tag, input logic [31:0] exp, input int exp_edges, input int start);
        int edges;
        int busy_n;
        edges  = start;
        busy_n = start;
        while (rvm_res_rdy_o !== 1'b1 && edges < 40) begin
            if (rvm_busy_o === 1'b1) busy_n++;
            @(negedge clk);
            edges++;
        end
        chk({tag, "_lat"}, edges, exp_edges);
        chk({tag, "_res"}, rvm_res_o, exp);
        chk({tag, "_busycyc"}, busy_n, exp_edges);
        chk({tag, "_busy_at_rdy"}, {31'b0, rvm_busy_o}, 32'd0);
        last_exp = exp;
    endtask

    task automatic run_core(input string tag, input logic [2:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input bit tail);
        int lat;
        lat = is_fast(c, a, b) ? 0 : 32;
        issue(c, a, b);
        wait_res(tag, exp, lat, 0);
        if (tail) begin
            @(negedge clk);
            chk({tag, "_pulse1"}, {31'b0, rvm_res_rdy_o}, 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;
        int          mode;

        // reset values
        #3 rst_n = 1'b0;
        #4;
        chk("rst_res", rvm_res_o, 32'd0);
        chk("rst_rdy", {31'b0, rvm_res_rdy_o}, 32'd0);
        chk("rst_busy", {31'b0, rvm_busy_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors
        run_core("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        run_core("mulhu_ones",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
        run_core("mulh_ones",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_core("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b1);
        run_core("divu_by0",    3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1'b1);
        run_core("remu_by0",    3'd7, 32'd100,        32'd0,         32'd100,       1'b1);
        run_core("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_core("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1'b1);
        run_core("remu_7_2",    3'd7, 32'd7,          32'd2,         32'd1,         1'b1);

        // back-to-back commands presented during the ready cycle
        run_core("b2b_div",   3'd4, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 1'b0);
        run_core("b2b_rem",   3'd6, 32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 1'b0);
        run_core("b2b_divu0", 3'd5, 32'd100,       32'd0,  32'hFFFF_FFFF, 1'b0);
        run_core("b2b_remu0", 3'd7, 32'd100,       32'd0,  32'd100,       1'b0);
        run_core("b2b_mul",   3'd0, 32'd11,        32'd13, 32'd143,       1'b1);

        // a command presented during ITER is ignored
        issue(3'd7, 32'd7, 32'd2);
        repeat (4) @(negedge clk);
        rvm_cmd_vd_i = 1'b1;
        rvm_cmd_i    = 3'd5;
        rvm_op1_i    = 32'd9;
        rvm_op2_i    = 32'd0;
        @(negedge clk);
        rvm_cmd_vd_i = 1'b0;
        wait_res("iter_ignore", 32'd1, 32, 5);
        @(negedge clk);

        // kill 10 cycles after accepting a DIVU, then a MUL accepted immediately
        issue(3'd5, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        rvm_kill_i = 1'b1;
        @(negedge clk);
        rvm_kill_i = 1'b0;
        chk("kill_busy", {31'b0, rvm_busy_o}, 32'd0);
        chk("kill_rdy", {31'b0, rvm_res_rdy_o}, 32'd0);
        chk("kill_res", rvm_res_o, last_exp);
        run_core("kill_then_mul", 3'd0, 32'd3, 32'd4, 32'd12, 1'b1);

        // kill and command on the same edge: kill wins
        rvm_kill_i = 1'b1;
        issue(3'd0, 32'd5, 32'd6);
        rvm_kill_i = 1'b0;
        chk("killcmd_busy", {31'b0, rvm_busy_o}, 32'd0);
        chk("killcmd_rdy", {31'b0, rvm_res_rdy_o}, 32'd0);
        @(negedge clk);
        chk("killcmd_busy2", {31'b0, rvm_busy_o}, 32'd0);

        // kill on the final step edge: no pulse and the result is unchanged
        issue(3'd0, 32'd5, 32'd6);
        repeat (31) @(negedge clk);
        chk("killT32_busy_pre", {31'b0, rvm_busy_o}, 32'd1);
        rvm_kill_i = 1'b1;
        @(negedge clk);
        rvm_kill_i = 1'b0;
        chk("killT32_rdy", {31'b0, rvm_res_rdy_o}, 32'd0);
        chk("killT32_busy", {31'b0, rvm_busy_o}, 32'd0);
        chk("killT32_res", rvm_res_o, last_exp);

        // kill while in DONE: the pulse has already been issued
        run_core("killdone", 3'd0, 32'd5, 32'd6, 32'd30, 1'b0);
        rvm_kill_i = 1'b1;
        @(negedge clk);
        rvm_kill_i = 1'b0;
        chk("killdone_rdy", {31'b0, rvm_res_rdy_o}, 32'd0);
        chk("killdone_res", rvm_res_o, 32'd30);

        // randomized operations against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            c    = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 7);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) begin
                b = 32'd0;
            end else if (mode == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (mode == 2) begin
                a = 32'($urandom_range(0, 40)) - 32'd20;
                b = 32'($urandom_range(0, 10)) - 32'd5;
            end
            run_core($sformatf("rnd%0d_c%0d", i, c), c, a, b, model(c, a, b), 1'b1);
        end

        // reset in the middle of ITER
        issue(3'd0, 32'd123, 32'd456);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_res", rvm_res_o, 32'd0);
        chk("midrst_rdy", {31'b0, rvm_res_rdy_o}, 32'd0);
        chk("midrst_busy", {31'b0, rvm_busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rvm_res_rdy_o === 1'b1 || rvm_busy_o === 1'b1) seen++;
        end
        chk("midrst_quiet", seen, 32'd0);
        last_exp = '0;
        run_core("after_rst", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
